// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronised line, 16x oversampling, 3-sample majority vote at mid-bit.
// Delivers bytes with a one-cycle valid pulse plus framing-error and sticky overrun flags.
`timescale 1ns/1ps
module uart_rx #(
  parameter logic [9:0] OVERSAMPLE_DIV = 10'd53,
  parameter int         SYNC_STAGES    = 2
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       rx_i,
  input  logic       ack_i,
  output logic [7:0] data_out_o,
  output logic       valid_o,
  output logic       frame_err_o,
  output logic       overrun_o,
  output logic       busy_o
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [SYNC_STAGES-1:0] sync_q;
  logic       rx_s, rx_prev_q;
  logic [1:0] state_q, state_d;
  logic [9:0] div_q, div_d;
  logic [3:0] scnt_q, scnt_d;
  logic [2:0] idx_q, idx_d;
  logic       s7_q, s7_d, s8_q, s8_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] data_q, data_d;
  logic       valid_q, valid_d, fe_q, fe_d;
  logic       pend_q, pend_d, ovr_q, ovr_d;
  logic       tick, mid, last, fall, bit_val, got;

  assign rx_s    = sync_q[SYNC_STAGES-1];
  assign fall    = rx_prev_q & ~rx_s;
  assign tick    = (state_q != S_IDLE) && (div_q == OVERSAMPLE_DIV);
  assign mid     = tick && (scnt_q == 4'd9);
  assign last    = tick && (scnt_q == 4'd15);
  assign bit_val = (s7_q & s8_q) | (s7_q & rx_s) | (s8_q & rx_s);
  assign got     = (state_q == S_STOP) && mid && bit_val;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync_q    <= '1;
      rx_prev_q <= 1'b1;
    end else begin
      if (SYNC_STAGES > 1) sync_q <= {sync_q[SYNC_STAGES-2:0], rx_i};
      else                 sync_q <= rx_i;
      rx_prev_q <= rx_s;
    end
  end

  always_comb begin
    state_d = state_q;
    scnt_d  = scnt_q;
    idx_d   = idx_q;
    s7_d    = s7_q;
    s8_d    = s8_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    fe_d    = 1'b0;
    pend_d  = pend_q;
    ovr_d   = ovr_q;
    // Divider held at zero while idle so bit phase starts at the detected edge
    if (state_q == S_IDLE || div_q == OVERSAMPLE_DIV) div_d = 10'd0;
    else                                             div_d = div_q + 10'd1;
    if (tick) begin
      scnt_d = scnt_q + 4'd1;
      if (scnt_q == 4'd7) s7_d = rx_s;
      if (scnt_q == 4'd8) s8_d = rx_s;
    end
    case (state_q)
      S_IDLE: if (fall) begin
        state_d = S_START;
        scnt_d  = 4'd0;
      end
      S_START: begin
        if (mid && bit_val) state_d = S_IDLE;
        else if (last) begin
          state_d = S_DATA;
          idx_d   = 3'd0;
        end
      end
      S_DATA: begin
        if (mid) shift_d = {bit_val, shift_q[7:1]};
        if (last) begin
          if (idx_q == 3'd7) state_d = S_STOP;
          else               idx_d   = idx_q + 3'd1;
        end
      end
      default: if (mid) begin
        // Leave on the mid-stop sample so a following start bit is not missed
        state_d = S_IDLE;
        if (bit_val) begin
          data_d  = shift_q;
          valid_d = 1'b1;
        end else begin
          fe_d = 1'b1;
        end
      end
    endcase
    if (ack_i) begin
      pend_d = 1'b0;
      ovr_d  = 1'b0;
    end
    if (got) begin
      pend_d = 1'b1;
      if (pend_q && !ack_i) ovr_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      scnt_q  <= '0;
      idx_q   <= '0;
      s7_q    <= 1'b0;
      s8_q    <= 1'b0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      fe_q    <= 1'b0;
      pend_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      scnt_q  <= scnt_d;
      idx_q   <= idx_d;
      s7_q    <= s7_d;
      s8_q    <= s8_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      fe_q    <= fe_d;
      pend_q  <= pend_d;
      ovr_q   <= ovr_d;
    end
  end

  assign data_out_o  = data_q;
  assign valid_o     = valid_q;
  assign frame_err_o = fe_q;
  assign overrun_o   = ovr_q;
  assign busy_o      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: timed serial-line driver, pulse monitor and a frame-level reference model.
`timescale 1ns/1ps
module tb_uart_rx;
  localparam logic [9:0] DIV = 10'd9;
  localparam int BIT_NS = 16 * (int'(DIV) + 1) * 10;

  logic clk, resetn, rx, ack;
  logic [7:0] data_out;
  logic valid, frame_err, overrun, busy;

  uart_rx #(.OVERSAMPLE_DIV(DIV), .SYNC_STAGES(2)) dut (
    .clk(clk), .resetn(resetn), .rx_i(rx), .ack_i(ack),
    .data_out_o(data_out), .valid_o(valid), .frame_err_o(frame_err),
    .overrun_o(overrun), .busy_o(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tot = 0, n_bad = 0;
  int vcnt = 0, fecnt = 0;
  logic [7:0] obs_q[$];

  // Reference model state: what the consumer should currently see
  logic [7:0] m_last;
  bit m_pend, m_ovr;

  always @(negedge clk) begin
    if (valid) begin
      vcnt++;
      obs_q.push_back(data_out);
    end
    if (frame_err) fecnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] b, input bit stop, input int bns);
    rx = 1'b0;
    #bns;
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      #bns;
    end
    rx = stop;
    #bns;
    rx = 1'b1;
  endtask

  task automatic do_ack();
    @(posedge clk); #1 ack = 1'b1;
    @(posedge clk); #1 ack = 1'b0;
    m_pend = 0;
    m_ovr  = 0;
    @(negedge clk);
    chk("overrun_after_ack", overrun, 0);
  endtask

  task automatic frame(input logic [7:0] b, input bit stop, input int bns, input bit ack_after);
    int v0, f0;
    v0 = vcnt;
    f0 = fecnt;
    send(b, stop, bns);
    repeat (3) @(negedge clk);
    if (stop) begin
      if (m_pend) m_ovr = 1;
      m_pend = 1;
      m_last = b;
    end
    chk("valid_cnt", vcnt - v0, stop ? 1 : 0);
    chk("ferr_cnt", fecnt - f0, stop ? 0 : 1);
    chk("data_out", data_out, m_last);
    while (obs_q.size() > 0) chk("valid_byte", obs_q.pop_front(), b);
    chk("overrun", overrun, m_ovr);
    chk("busy_end", busy, 0);
    if (ack_after) do_ack();
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: run did not complete in time");
    $fatal(1);
  end

  initial begin
    int v0, f0;
    resetn = 1'b0; rx = 1'b1; ack = 1'b0;
    m_last = 8'h00; m_pend = 0; m_ovr = 0;
    repeat (3) @(negedge clk);
    chk("rst_data", data_out, 0);
    chk("rst_valid", valid, 0);
    chk("rst_ferr", frame_err, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_busy", busy, 0);
    resetn = 1'b1;
    repeat (5) @(negedge clk);

    // single byte, busy visible mid-frame
    fork
      frame(8'h55, 1, BIT_NS, 1);
      begin #(4 * BIT_NS); chk("busy_mid", busy, 1); end
    join

    // back-to-back frames, ack lands during the second frame
    v0 = vcnt;
    fork
      begin send(8'hA3, 1, BIT_NS); send(8'h0F, 1, BIT_NS); end
      begin #(13 * BIT_NS); @(posedge clk); #1 ack = 1'b1; @(posedge clk); #1 ack = 1'b0; end
    join
    repeat (3) @(negedge clk);
    chk("b2b_cnt", vcnt - v0, 2);
    chk("b2b_first", obs_q.size() > 0 ? obs_q.pop_front() : 8'hxx, 8'hA3);
    chk("b2b_second", obs_q.size() > 0 ? obs_q.pop_front() : 8'hxx, 8'h0F);
    chk("b2b_overrun", overrun, 0);
    m_last = 8'h0F; m_pend = 1; m_ovr = 0;
    do_ack();

    // bad stop bit: frame error, data_out kept
    frame(8'h3C, 0, BIT_NS, 0);

    // break: line held low through and beyond the stop bit
    v0 = vcnt; f0 = fecnt;
    rx = 1'b0;
    #(13 * BIT_NS);
    chk("break_busy", busy, 0);
    rx = 1'b1;
    #(2 * BIT_NS);
    chk("break_ferr", fecnt - f0, 1);
    chk("break_valid", vcnt - v0, 0);

    // short glitch is a false start
    v0 = vcnt; f0 = fecnt;
    rx = 1'b0;
    #(BIT_NS / 4);
    rx = 1'b1;
    #(2 * BIT_NS);
    chk("glitch_valid", vcnt - v0, 0);
    chk("glitch_ferr", fecnt - f0, 0);
    chk("glitch_busy", busy, 0);
    frame(8'h81, 1, BIT_NS, 1);

    // overrun with ack held low
    frame(8'h11, 1, BIT_NS, 0);
    frame(8'h22, 1, BIT_NS, 0);
    chk("ovr_set", overrun, 1);
    do_ack();

    // reset in the middle of data bit 4
    v0 = vcnt; f0 = fecnt;
    fork
      send(8'hFF, 1, BIT_NS);
      begin
        #(BIT_NS * 11 / 2);
        resetn = 1'b0;
        #1;
        chk("midrst_busy", busy, 0);
        #100 resetn = 1'b1;
      end
    join
    m_last = 8'h00; m_pend = 0; m_ovr = 0;
    repeat (3) @(negedge clk);
    chk("abort_valid", vcnt - v0, 0);
    chk("abort_ferr", fecnt - f0, 0);
    chk("abort_data", data_out, 0);
    frame(8'h96, 1, BIT_NS, 1);
    frame(8'h96, 1, BIT_NS * 98 / 100, 1);
    frame(8'h96, 1, BIT_NS * 102 / 100, 1);

    // randomized frames: data, stop bit, mild skew, ack policy, idle gap
    for (int k = 0; k < 12; k++) begin
      logic [7:0] b;
      bit st, ak;
      int bns;
      b   = 8'($urandom);
      st  = ($urandom_range(0, 5) != 0);
      ak  = 1'($urandom_range(0, 1));
      bns = BIT_NS + int'($urandom_range(0, 48)) - 24;
      frame(b, st, bns, ak);
      #($urandom_range(0, BIT_NS));
    end

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end
endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
UART receiver that mates with the team's UART transmitter. Frame format: 8N1, LSB first, idle high.
- Synchronises the serial line and oversamples it by 16.
- Samples each bit at mid-bit using a 3-sample majority vote.
- Delivers each received byte with a one-cycle valid pulse, plus framing- and overrun-error flags.
- Sits between the board RX pin and the reliable-transmission link layer.

Parameters:
OVERSAMPLE_DIV, 10'd53, oversample tick period in clk cycles minus 1: tick every OVERSAMPLE_DIV+1 cycles. 100 MHz/(54*16) ≈ 115.7 kbaud, matching the TX block's 115200 setting.
SYNC_STAGES, 2, depth of the rx input synchroniser flops (minimum 2).

Ports:
clk  input  1  system clock, 100 MHz nominal
resetn  input  1  asynchronous, active-low reset
rx  input  1  serial line, asynchronous to clk, idle high
data_out  output  8  last received byte; held stable until the next valid pulse
valid  output  1  one-cycle pulse when a byte with a correct stop bit is received
frame_err  output  1  one-cycle pulse when the stop bit samples low
overrun  output  1  sticky; set when valid fires while ack=0 and the previous byte was unacknowledged; cleared by ack
ack  input  1  consumer has taken data_out; clears the pending and overrun flags
busy  output  1  high from start-edge detection until return to IDLE

Behaviour:
- Reset (resetn=0, async):
  - data_out=8'h00, valid=0, frame_err=0, overrun=0, busy=0.
  - Synchroniser flops=1, FSM=IDLE, all counters=0, pending=0.
- Synchroniser: rx passes through SYNC_STAGES flops giving rx_s. All logic uses rx_s only.
- Tick generator: 10-bit counter.
  - Wraps to 0 at OVERSAMPLE_DIV; tick=1 on the wrap cycle.
  - Counter is forced to 0 while FSM=IDLE, so bit phase is aligned to the start edge.
- sample_cnt: 4-bit count of ticks within a bit, 0..15; wraps naturally.
- Majority sample: rx_s is captured at sample_cnt 7, 8 and 9. bit_val = majority of the 3 samples, evaluated on the tick where sample_cnt=9.
- FSM states:
  - IDLE:
    - busy=0.
    - A falling edge (rx_s=0 and previous rx_s=1) goes to START and clears sample_cnt.
  - START:
    - busy=1.
    - At sample_cnt=9: if bit_val=1, this is a false start; go to IDLE with no outputs.
    - Otherwise, on the tick where sample_cnt=15, go to DATA with bit_idx=0.
  - DATA:
    - At sample_cnt=9, bit_val is shifted in at the MSB of shift_reg (right shift), so LSB-first bits assemble correctly.
    - On the sample_cnt=15 tick: if bit_idx=7, go to STOP; else bit_idx+1.
  - STOP:
    - At sample_cnt=9, evaluate bit_val.
      - bit_val=1: data_out<=shift_reg and valid=1 on the next clk. If pending=1 and ack=0 in that cycle, set overrun. Then set pending=1.
      - bit_val=0: frame_err=1 for one cycle; data_out is unchanged and pending is unchanged.
    - In both cases go to IDLE immediately after the sample_cnt=9 tick. The remaining half stop bit is skipped, allowing back-to-back frames.
- Latency: valid asserts 1 clk after the mid-stop-bit sample tick, about 9.5 bit times after the start edge.
- ack handling:
  - ack=1 clears pending and overrun on the next clk.
  - If ack=1 in the same cycle as valid, pending ends at 1 (the new byte) and overrun is not set.
- Break (rx held low through the stop bit): frame_err pulses. IDLE is then left only after rx_s goes high and then falls again. No repeated frame_err while rx is held low.
- Glitches on rx shorter than about 7/16 of a bit in START are rejected as false starts.
- A deassert-free mid-frame reset aborts the frame immediately: no valid, no frame_err.
- Outputs are registered; no combinational path from rx to any output.

Test Plan:
1. Reset, then send 0x55 at nominal baud via a TX-model -> exactly one valid pulse, data_out=8'h55, frame_err=0, busy falls after the stop bit sample.
2. Send 0xA3 then 0x0F back to back (stop bit immediately followed by start) with ack after each -> two valid pulses, data 8'hA3 then 8'h0F, overrun stays 0.
3. Send 0x3C with the stop bit driven low -> frame_err one-cycle pulse, no valid, data_out keeps its prior value.
4. Pull rx low for 4 oversample ticks (about 1/4 bit) then high -> returns to IDLE, no valid, no frame_err; a following 0x81 frame is received correctly.
5. Send 0x11 and 0x22 with ack held 0 -> second valid sets overrun=1, data_out=8'h22; pulse ack -> overrun=0.
6. Assert resetn=0 during DATA bit 4 of frame 0xFF, release, then send 0x96 -> no output from the aborted frame, 0x96 received correctly; also apply ±2% baud skew on 0x96 -> still correct.
